// File: rtl/flash_reader_pkg.sv
// Shared types and constants for the SPI-mode-0 flash read initiator.
// FLASH_READER_FAST_READ_EN selects the 0x0B fast-read command with 8 dummy clocks.
package flash_reader_pkg;

    localparam logic [7:0] CmdRead     = 8'h03;
    localparam logic [7:0] CmdFastRead = 8'h0B;
    localparam int         AddressBits = 24;
    localparam int         DummyCycles = 8;
    localparam int         BitCntWidth = 5;

`ifdef FLASH_READER_FAST_READ_EN
    localparam logic [7:0] ReadCommand = CmdFastRead;
`else
    localparam logic [7:0] ReadCommand = CmdRead;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMMAND,
        ST_ADDRESS,
`ifdef FLASH_READER_FAST_READ_EN
        ST_DUMMY,
`endif
        ST_DATA,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/flash_reader_shifter.sv
// SCK phase generator plus MOSI/MISO shift registers; two clk per SCK bit.
// MOSI changes with the falling SCK edge, MISO is sampled as SCK drops.
module flash_reader_shifter
    import flash_reader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [7:0]             load_byte,
    input  logic                   advance,
    input  logic                   stall,
    input  logic [7:0]             next_byte,
    input  logic                   miso,
    output logic                   sck,
    output logic                   mosi,
    output logic [7:0]             rx_byte,
    output logic [BitCntWidth-1:0] bit_cnt,
    output logic                   bit_done,
    output logic                   byte_done
);

    logic                   phase_q, phase_d;
    logic                   sck_q, sck_d;
    logic [7:0]             mosi_sr_q, mosi_sr_d;
    logic [7:0]             rx_sr_q, rx_sr_d;
    logic [BitCntWidth-1:0] bit_cnt_q, bit_cnt_d;
    logic                   hold;
    logic                   step;

    // Back-pressure only bites at the start of a byte, before SCK rises.
    assign hold      = stall && !phase_q && (bit_cnt_q[2:0] == 3'd0);
    assign step      = advance && !hold;
    assign bit_done  = step && phase_q;
    assign byte_done = bit_done && (bit_cnt_q[2:0] == 3'd7);
    assign rx_byte   = {rx_sr_q[6:0], miso};

    // NOTE: every always_comb target gets its default first so no path can infer a latch.
    always_comb begin
        phase_d   = phase_q;
        sck_d     = sck_q;
        mosi_sr_d = mosi_sr_q;
        rx_sr_d   = rx_sr_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            phase_d   = 1'b0;
            sck_d     = 1'b0;
            mosi_sr_d = load_byte;
            bit_cnt_d = '0;
        end else if (!advance) begin
            phase_d = 1'b0;
            sck_d   = 1'b0;
        end else if (step) begin
            if (!phase_q) begin
                phase_d = 1'b1;
                sck_d   = 1'b1;
            end else begin
                phase_d   = 1'b0;
                sck_d     = 1'b0;
                rx_sr_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 1'b1;
                mosi_sr_d = byte_done ? next_byte : {mosi_sr_q[6:0], 1'b0};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= 1'b0;
            sck_q     <= 1'b0;
            mosi_sr_q <= '0;
            rx_sr_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            phase_q   <= phase_d;
            sck_q     <= sck_d;
            mosi_sr_q <= mosi_sr_d;
            rx_sr_q   <= rx_sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign sck     = sck_q;
    assign mosi    = mosi_sr_q[7];
    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/flash_reader.sv
// Serial flash read initiator: command + 24-bit address, then bytes to a valid/ready sink.
// Define FLASH_READER_FAST_READ_EN for the 0x0B command with a Dummy phase.
module flash_reader
    import flash_reader_pkg::*;
#(
    parameter int CountBitWidth = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [AddressBits-1:0]   start_address,
    input  logic [CountBitWidth-1:0] byte_count,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               data_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic                     flash_clk,
    output logic                     flash_cs,
    output logic                     flash_mosi,
    input  logic                     flash_miso
);

    state_e                   state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     cs_q, cs_d;
    logic [7:0]               data_out_q, data_out_d;
    logic                     data_valid_q, data_valid_d;
    logic [CountBitWidth-1:0] remaining_q, remaining_d;
    logic [AddressBits-1:0]   addr_q, addr_d;

    logic                   load;
    logic                   advance;
    logic                   stall;
    logic                   consume;
    logic [7:0]             next_byte;
    logic [7:0]             rx_byte;
    logic [BitCntWidth-1:0] bit_cnt;
    logic                   bit_done;
    logic                   byte_done;

    assign load    = (state_q == ST_IDLE) && start && (byte_count != '0);
    assign consume = data_valid_q && data_ready;
    assign stall   = (state_q == ST_DATA) && data_valid_q && !data_ready;

    always_comb begin
        advance   = 1'b0;
        next_byte = 8'h00;
        case (state_q)
            ST_COMMAND: begin
                advance   = 1'b1;
                next_byte = addr_q[23:16];
            end
            ST_ADDRESS: begin
                advance = 1'b1;
                // The bit counter's upper bits say which address byte just finished.
                case (bit_cnt[4:3])
                    2'd1:    next_byte = addr_q[15:8];
                    2'd2:    next_byte = addr_q[7:0];
                    default: next_byte = 8'h00;
                endcase
            end
`ifdef FLASH_READER_FAST_READ_EN
            ST_DUMMY:   advance = 1'b1;
`endif
            ST_DATA:    advance = 1'b1;
            default:    advance = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cs_d         = cs_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q && !consume;
        remaining_d  = remaining_q;
        addr_d       = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (byte_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d      = start_address;
                        remaining_d = byte_count;
                        cs_d        = 1'b0;
                        state_d     = ST_COMMAND;
                    end
                end
            end
            ST_COMMAND: begin
                if (bit_done && bit_cnt == 5'd7) state_d = ST_ADDRESS;
            end
            ST_ADDRESS: begin
                if (bit_done && bit_cnt == 5'd31) begin
`ifdef FLASH_READER_FAST_READ_EN
                    state_d = ST_DUMMY;
`else
                    state_d = ST_DATA;
`endif
                end
            end
`ifdef FLASH_READER_FAST_READ_EN
            ST_DUMMY: begin
                if (bit_done && bit_cnt == 5'(DummyCycles - 1)) state_d = ST_DATA;
            end
`endif
            ST_DATA: begin
                if (byte_done) begin
                    data_out_d   = rx_byte;
                    data_valid_d = 1'b1;
                    remaining_d  = remaining_q - 1'b1;
                    if (remaining_q == CountBitWidth'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cs_d = 1'b1;
                if (!data_valid_q || consume) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cs_q         <= 1'b1;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            remaining_q  <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cs_q         <= cs_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            remaining_q  <= remaining_d;
            addr_q       <= addr_d;
        end
    end

    flash_reader_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_byte (ReadCommand),
        .advance   (advance),
        .stall     (stall),
        .next_byte (next_byte),
        .miso      (flash_miso),
        .sck       (flash_clk),
        .mosi      (flash_mosi),
        .rx_byte   (rx_byte),
        .bit_cnt   (bit_cnt),
        .bit_done  (bit_done),
        .byte_done (byte_done)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign flash_cs   = cs_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_flash_reader.sv
// Bench for flash_reader against a behavioural flash holding byte i = i[7:0].
// Expected bytes are queued at start and popped on each valid/ready handshake.
module tb_flash_reader;

    localparam int CW = 16;
`ifdef FLASH_READER_FAST_READ_EN
    localparam int          HDR_BITS  = 40;
    localparam logic [7:0]  EXP_CMD   = 8'h0B;
    localparam int unsigned FIRST_LAT = 96;
`else
    localparam int          HDR_BITS  = 32;
    localparam logic [7:0]  EXP_CMD   = 8'h03;
    localparam int unsigned FIRST_LAT = 80;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [23:0]   start_address;
    logic [CW-1:0] byte_count;
    logic          busy;
    logic          done;
    logic [7:0]    data_out;
    logic          data_valid;
    logic          data_ready;
    logic          flash_clk;
    logic          flash_cs;
    logic          flash_mosi;
    logic          flash_miso = 1'b0;

    flash_reader #(.CountBitWidth(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_address (start_address),
        .byte_count    (byte_count),
        .busy          (busy),
        .done          (done),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .flash_clk     (flash_clk),
        .flash_cs      (flash_cs),
        .flash_mosi    (flash_mosi),
        .flash_miso    (flash_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    int unsigned e0 = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural flash: MOSI captured on rising SCK, MISO driven on falling SCK.
    int unsigned fm_bits = 0;
    logic [31:0] fm_hdr = '0;
    logic [7:0]  fm_dummy = '0;

    always @(posedge flash_clk or posedge flash_cs or negedge rst_n) begin
        if (!rst_n || flash_cs) begin
            fm_bits  = 0;
            fm_hdr   = '0;
            fm_dummy = '0;
        end else begin
            if (fm_bits < 32) fm_hdr = {fm_hdr[30:0], flash_mosi};
            else if (fm_bits < HDR_BITS) fm_dummy = {fm_dummy[6:0], flash_mosi};
            fm_bits++;
        end
    end

    always @(negedge flash_clk) begin
        int unsigned idx;
        logic [23:0] a;
        logic [7:0]  b;
        if (!flash_cs && fm_bits >= HDR_BITS) begin
            idx        = fm_bits - HDR_BITS;
            a          = fm_hdr[23:0] + 24'(idx / 8);
            b          = a[7:0];
            flash_miso = b[3'(7 - (idx % 8))];
        end
    end

    logic [7:0] sb_q[$];

    always @(negedge clk) begin
        bit have;
        if (rst_n && data_valid && data_ready) begin
            have = (sb_q.size() != 0);
            check("sb_have_expected", 32'(have), 32'd1);
            if (have) check("sb_data", 32'(data_out), 32'(sb_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [23:0] addr, input logic [CW-1:0] cnt);
        start_address = addr;
        byte_count    = cnt;
        start         = 1'b1;
        for (int i = 0; i < int'(cnt); i++) begin
            logic [23:0] a;
            a = addr + 24'(i);
            sb_q.push_back(a[7:0]);
        end
        tick();
        start         = 1'b0;
        start_address = ~addr;
        byte_count    = ~cnt;
        e0            = cyc_cnt;
    endtask

    task automatic wait_valid(input string tag, output int unsigned lat);
        int unsigned n = 0;
        while (!data_valid && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_valid_seen"}, 32'(data_valid), 32'd1);
        lat = cyc_cnt - e0;
    endtask

    task automatic wait_done(input string tag);
        int unsigned n = 0;
        while (!done && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        tick();
    endtask

    task automatic check_header(input string tag, input logic [23:0] addr);
        check({tag, "_cmd"}, 32'(fm_hdr[31:24]), 32'(EXP_CMD));
        check({tag, "_addr"}, 32'(fm_hdr[23:0]), 32'(addr));
`ifdef FLASH_READER_FAST_READ_EN
        check({tag, "_dummy_mosi"}, 32'(fm_dummy), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at time limit, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat;
        bit sck_any, cs_any, valid_lost;

        rst_n = 1'b0; start = 1'b0; start_address = '0; byte_count = '0; data_ready = 1'b1;
        repeat (3) tick();
        check("rst_cs", 32'(flash_cs), 32'd1);
        check("rst_sck", 32'(flash_clk), 32'd0);
        check("rst_mosi", 32'(flash_mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single byte
        start_xfer(24'h000000, 16'd1);
        check("t1_cs_low", 32'(flash_cs), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_mosi_cmd7", 32'(flash_mosi), 32'(EXP_CMD[7]));
        wait_valid("t1", lat);
        check("t1_latency", lat, FIRST_LAT);
        check_header("t1", 24'h000000);
        tick();
        check("t1_cs_high", 32'(flash_cs), 32'd1);
        check("t1_done_early", 32'(done), 32'd0);
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_low", 32'(busy), 32'd0);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);

        // Multi-byte streaming
        start_xfer(24'h000000, 16'd4);
        for (int i = 0; i < 4; i++) begin
            wait_valid("t2", lat);
            check($sformatf("t2_latency_%0d", i), lat, FIRST_LAT + 16 * i);
            if (i == 0) check_header("t2", 24'h000000);
            tick();
        end
        wait_done("t2");

        // Back-pressure
        data_ready = 1'b0;
        start_xfer(24'h123456, 16'd3);
        wait_valid("t3", lat);
        check("t3_latency", lat, FIRST_LAT);
        check_header("t3", 24'h123456);
        sck_any = 1'b0; cs_any = 1'b0; valid_lost = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            sck_any    |= flash_clk;
            cs_any     |= flash_cs;
            valid_lost |= !data_valid;
        end
        check("t3_sck_frozen", 32'(sck_any), 32'd0);
        check("t3_cs_held", 32'(cs_any), 32'd0);
        check("t3_valid_held", 32'(valid_lost), 32'd0);
        check("t3_data_held", 32'(data_out), 32'h56);
        data_ready = 1'b1;
        wait_done("t3");

        // Zero count
        start_xfer(24'h000100, 16'd0);
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_done_early", 32'(done), 32'd0);
        check("t4_cs", 32'(flash_cs), 32'd1);
        tick();
        check("t4_done", 32'(done), 32'd1);
        check("t4_busy_low", 32'(busy), 32'd0);
        check("t4_cs_after", 32'(flash_cs), 32'd1);
        tick();
        check("t4_done_pulse", 32'(done), 32'd0);

        // Reset in the middle of the address phase
        start_xfer(24'h000000, 16'd2);
        while (cyc_cnt - e0 < 31) tick();
        check("t5_sck_pre", 32'(flash_clk), 32'd1);
        check("t5_cs_pre", 32'(flash_cs), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t5_cs", 32'(flash_cs), 32'd1);
        check("t5_sck", 32'(flash_clk), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        start_xfer(24'h000000, 16'd1);
        wait_valid("t5", lat);
        check("t5_latency", lat, FIRST_LAT);
        check("t5_data", 32'(data_out), 32'h00);
        wait_done("t5");

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
